crossing_sched: RTL and testbench
=================================

# crossing_sched

Two-direction intersection scheduler for the traffic-light design. It sequences a north-south (NS) and an east-west (EW) light pair plus a shared pedestrian phase, paced by the blinker timebase. It sits between the debouncers/blinker and two `light` colour converters, and replaces the single-direction `control` unit when the board drives a crossing. Its light codes match the `light` select encoding.

## Interface
- C_INT_GREEN, 40: minimum green interval [blinks], ≥1
- C_INT_YELLOW, 10: yellow interval [blinks], ≥1
- C_INT_CLEAR, 5: all-red clearance interval [blinks], ≥1
- C_INT_WALK, 40: pedestrian walk interval [blinks], ≥1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- blink  in  1  one-cycle timebase pulse from blinker
- inReqNS  in  1  NS vehicle demand, level, already debounced
- inReqEW  in  1  EW vehicle demand, level, already debounced
- inPedestrian  in  1  pedestrian button, debounced level
- inFlash  in  1  night-flash request, level (used only with SCHED_FLASH_EN)
- outLightNS  out  2  NS light code: 0 red, 1 green, 2 yellow, 3 walk
- outLightEW  out  2  EW light code, same encoding
- outWalk  out  1  pedestrian walk lamp
- outPedLatch  out  1  pending pedestrian request
- outState  out  3  FSM state: 0 CLEAR, 1 NS_GREEN, 2 NS_YELLOW, 3 EW_GREEN, 4 EW_YELLOW, 5 WALK, 6 FLASH

## Operation
- Interval counter counts `blink` pulses in the current state. It is cleared on every state change and saturates at its maximum. Width is clog2(max interval)+1.
- Interval expiry for state S means a `blink` arriving while cnt == C_INT_S−1.
- CLEAR: both lights red. On expiry, the next state is chosen in this priority order:
  - FLASH, if the flash feature is built in and inFlash=1
  - WALK, if outPedLatch=1 and the previous state was not WALK
  - otherwise the green named by nextDir
- NS_GREEN / EW_GREEN: the minimum interval must expire first. After that, exit to the matching yellow on the first `blink` where demand exists.
  - Demand for NS_GREEN is inReqEW | outPedLatch | flashReq.
  - Demand for EW_GREEN is inReqNS | outPedLatch | flashReq.
  - With no demand, green holds indefinitely.
- NS_YELLOW / EW_YELLOW: on expiry go to CLEAR. nextDir is set to the opposite direction.
- WALK: both lights 0 (red), outWalk=1. On expiry go to CLEAR; nextDir is unchanged.
- Pedestrian latch:
  - Set on a rising edge of inPedestrian, using a registered previous value.
  - Cleared on entry to WALK. If set and clear coincide, clear wins.
  - Rising edges while in WALK are ignored.
- Reset state: CLEAR, cnt=0, nextDir=NS, outPedLatch=0, outWalk=0, both lights 0, outState=0, edge register=0.
- Reset mid-operation returns immediately to this all-red state.

## Timing
- All outputs are registered and change only on clk rising edge.
- A state transition takes effect on the clk edge that samples the qualifying `blink`. Outputs reflect the new state in the same cycle as outState.
- outPedLatch rises 1 cycle after the sampled rising edge of inPedestrian.
- Requests are sampled only at `blink` cycles. A request that rises and falls between blinks does not cause an exit; the pedestrian latch is the exception, since it is edge-captured.
- The sequence guarantees that a green is never adjacent to the opposing green: at least C_INT_YELLOW+C_INT_CLEAR blinks lie between them.

## Configuration
- SCHED_FLASH_EN defined:
  - inFlash=1 counts as demand in either green, so the normal yellow and CLEAR sequence runs first.
  - On CLEAR expiry the FSM enters FLASH. FLASH takes precedence over WALK.
  - In FLASH a toggle flop flips on each `blink`; both lights show 2 when the toggle is 1 and 0 otherwise. outWalk=0, and the pedestrian latch still captures presses.
  - The FSM leaves FLASH on the first `blink` with inFlash=0, entering CLEAR with nextDir=NS.
- SCHED_FLASH_EN undefined: inFlash is ignored, the FLASH state and toggle are not built, and state code 6 is unreachable.

## Test plan
- Bench settings: blink every 4 clk, GREEN=4, YELLOW=2, CLEAR=1, WALK=3.
1. Reset → all outputs 0. After 1 blink, outState=1, outLightNS=1, outLightEW=0.
2. Hold inReqEW=1 from reset → NS_GREEN lasts 4 blinks, NS_YELLOW 2, CLEAR 1, then outState=3, outLightEW=1.
3. No demand → NS_GREEN holds for 50 blinks. Assert inReqEW → outLightNS=2 on the next blink.
4. Pulse inPedestrian during NS_GREEN → outPedLatch=1 one cycle later. The FSM runs NS_YELLOW→CLEAR→WALK with outWalk=1 for 3 blinks, then CLEAR, then EW_GREEN; outPedLatch=0 from WALK entry.
5. Rising edge on inPedestrian on the same cycle as WALK entry → outPedLatch=0 afterwards. A press during WALK is not latched.
6. With SCHED_FLASH_EN, inFlash=1 in EW_GREEN → EW_YELLOW, CLEAR, then outState=6 with lights alternating 2/0 each blink. Drop inFlash → CLEAR, then NS_GREEN.
7. Reset asserted mid-WALK → outputs return to 0 asynchronously, with no clk edge required.

Source files
------------

// File: rtl/crossing_sched.sv
// crossing_sched: two-direction intersection scheduler (NS / EW light pairs
// plus a shared pedestrian walk phase), paced by the blinker timebase.
// Optional night-flash mode is built only when SCHED_FLASH_EN is defined.
module crossing_sched #(
  parameter int C_INT_GREEN  = 40,
  parameter int C_INT_YELLOW = 10,
  parameter int C_INT_CLEAR  = 5,
  parameter int C_INT_WALK   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blink,
  input  logic       inReqNS,
  input  logic       inReqEW,
  input  logic       inPedestrian,
  input  logic       inFlash,
  output logic [1:0] outLightNS,
  output logic [1:0] outLightEW,
  output logic       outWalk,
  output logic       outPedLatch,
  output logic [2:0] outState
);

  localparam int MAX_GY  = (C_INT_GREEN > C_INT_YELLOW) ? C_INT_GREEN : C_INT_YELLOW;
  localparam int MAX_CW  = (C_INT_CLEAR > C_INT_WALK) ? C_INT_CLEAR : C_INT_WALK;
  localparam int MAX_INT = (MAX_GY > MAX_CW) ? MAX_GY : MAX_CW;
  localparam int CNT_W   = $clog2(MAX_INT) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(C_INT_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(C_INT_YELLOW - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(C_INT_CLEAR - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(C_INT_WALK - 1);

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_GREEN  = 2'd1;
  localparam logic [1:0] LIGHT_YELLOW = 2'd2;

  // nextDir encoding: 0 = NS green comes next, 1 = EW green comes next
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [2:0] {
    CLEAR     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5,
    FLASH     = 3'd6
  } state_t;

  state_t           state, stateD;
  logic [CNT_W-1:0] cnt, cntD;
  logic             nextDir, nextDirD;
  logic             pedPrev;
  logic             pedLatchD;
  logic             fromWalk;
  logic             flashReq;
  logic             toggleD;
  logic [1:0]       lightNSD, lightEWD;
  logic             walkD;
  logic             pedRise;
  logic             stateChange;

`ifdef SCHED_FLASH_EN
  logic toggle;
  assign flashReq = inFlash;
`else
  logic unusedFlash;
  assign unusedFlash = inFlash;
  assign flashReq    = 1'b0;
`endif

  assign pedRise     = inPedestrian & ~pedPrev;
  assign stateChange = (stateD != state);

  // Next-state, interval counter, latch and registered-output decode
  always_comb begin
    stateD   = state;
    nextDirD = nextDir;
    cntD     = cnt;
    toggleD  = 1'b0;
    lightNSD = LIGHT_RED;
    lightEWD = LIGHT_RED;
    walkD    = 1'b0;

    case (state)
      CLEAR: begin
        if (blink && cnt == CLEAR_LAST) begin
          if (flashReq)                      stateD = FLASH;
          else if (outPedLatch && !fromWalk) stateD = WALK;
          else if (nextDir == DIR_EW)        stateD = EW_GREEN;
          else                               stateD = NS_GREEN;
        end
      end
      NS_GREEN: begin
        if (blink && cnt >= GREEN_LAST && (inReqEW | outPedLatch | flashReq))
          stateD = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (blink && cnt == YELLOW_LAST) begin
          stateD   = CLEAR;
          nextDirD = DIR_EW;
        end
      end
      EW_GREEN: begin
        if (blink && cnt >= GREEN_LAST && (inReqNS | outPedLatch | flashReq))
          stateD = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (blink && cnt == YELLOW_LAST) begin
          stateD   = CLEAR;
          nextDirD = DIR_NS;
        end
      end
      WALK: begin
        if (blink && cnt == WALK_LAST) stateD = CLEAR;
      end
`ifdef SCHED_FLASH_EN
      FLASH: begin
        toggleD = blink ? ~toggle : toggle;
        if (blink && !inFlash) begin
          stateD   = CLEAR;
          nextDirD = DIR_NS;
        end
      end
`endif
      default: stateD = CLEAR;
    endcase

    if (stateD != state)              cntD = '0;
    else if (blink && cnt != CNT_MAX) cntD = cnt + 1'b1;

    // the toggle restarts from 0 on every entry into FLASH
    if (stateD != FLASH || state != FLASH) toggleD = 1'b0;

    case (stateD)
      NS_GREEN:  lightNSD = LIGHT_GREEN;
      NS_YELLOW: lightNSD = LIGHT_YELLOW;
      EW_GREEN:  lightEWD = LIGHT_GREEN;
      EW_YELLOW: lightEWD = LIGHT_YELLOW;
      WALK:      walkD    = 1'b1;
      FLASH: begin
        lightNSD = toggleD ? LIGHT_YELLOW : LIGHT_RED;
        lightEWD = toggleD ? LIGHT_YELLOW : LIGHT_RED;
      end
      default: ;
    endcase

    // entry into WALK clears the latch and beats a coincident press;
    // presses while already walking are ignored
    if (stateD == WALK && state != WALK) pedLatchD = 1'b0;
    else if (pedRise && state != WALK)   pedLatchD = 1'b1;
    else                                 pedLatchD = outPedLatch;
  end

  // State, counter, latch and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      cnt         <= '0;
      nextDir     <= DIR_NS;
      pedPrev     <= 1'b0;
      outPedLatch <= 1'b0;
      fromWalk    <= 1'b0;
      outLightNS  <= LIGHT_RED;
      outLightEW  <= LIGHT_RED;
      outWalk     <= 1'b0;
      outState    <= 3'd0;
`ifdef SCHED_FLASH_EN
      toggle      <= 1'b0;
`endif
    end else begin
      state       <= stateD;
      cnt         <= cntD;
      nextDir     <= nextDirD;
      pedPrev     <= inPedestrian;
      outPedLatch <= pedLatchD;
      if (stateChange) fromWalk <= (state == WALK);
      outLightNS  <= lightNSD;
      outLightEW  <= lightEWD;
      outWalk     <= walkD;
      outState    <= stateD;
`ifdef SCHED_FLASH_EN
      toggle      <= toggleD;
`endif
    end
  end

endmodule

// File: tb/tb_crossing_sched.sv
// Directed bench for crossing_sched: blink every 4 clk,
// GREEN=4, YELLOW=2, CLEAR=1, WALK=3.
module tb_crossing_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blink = 1'b0;
  logic       inReqNS = 1'b0;
  logic       inReqEW = 1'b0;
  logic       inPedestrian = 1'b0;
  logic       inFlash = 1'b0;
  logic [1:0] outLightNS, outLightEW;
  logic       outWalk, outPedLatch;
  logic [2:0] outState;

  int nCompared   = 0;
  int nMismatched = 0;

  crossing_sched #(
    .C_INT_GREEN (4),
    .C_INT_YELLOW(2),
    .C_INT_CLEAR (1),
    .C_INT_WALK  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .blink       (blink),
    .inReqNS     (inReqNS),
    .inReqEW     (inReqEW),
    .inPedestrian(inPedestrian),
    .inFlash     (inFlash),
    .outLightNS  (outLightNS),
    .outLightEW  (outLightEW),
    .outWalk     (outWalk),
    .outPedLatch (outPedLatch),
    .outState    (outState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       reqNS;
    logic       reqEW;
    logic [2:0] st;
    logic [1:0] ns;
    logic [1:0] ew;
    logic       walk;
    logic       latch;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [8:0] pack(input logic [2:0] st, input logic [1:0] ns,
                                      input logic [1:0] ew, input logic walk,
                                      input logic latch);
    return {st, ns, ew, walk, latch};
  endfunction

  function automatic logic [8:0] obs();
    return {outState, outLightNS, outLightEW, outWalk, outPedLatch};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h (st/ns/ew/walk/latch) expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic b);
    blink = b;
    @(posedge clk);
    #1;
    blink = 1'b0;
  endtask

  task automatic blinkStep();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  task automatic doReset();
    inReqNS = 1'b0; inReqEW = 1'b0; inPedestrian = 1'b0; inFlash = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // reset, enter NS_GREEN, press the button once the minimum green is served,
  // then follow NS_YELLOW into CLEAR
  task automatic pedToClear();
    doReset();
    blinkStep();
    repeat (3) blinkStep();
    check("preLatch", {8'd0, outPedLatch}, 9'd0);
    inPedestrian = 1'b1;
    cyc(1'b0);
    check("latchRise", {8'd0, outPedLatch}, 9'd1);
    inPedestrian = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    check("pedNsYellow", obs(), pack(3'd2, 2'd2, 2'd0, 1'b0, 1'b1));
    blinkStep();
    blinkStep();
    check("pedClear", obs(), pack(3'd0, 2'd0, 2'd0, 1'b0, 1'b1));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'd2, 2'd2, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'd2, 2'd2, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'd4, 2'd0, 2'd2, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'd4, 2'd0, 2'd2, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0};

    // reset state, then demand-driven cycle through both directions
    doReset();
    check("reset", obs(), 9'd0);
    for (int i = 0; i < 16; i++) begin
      inReqNS = tbl[i].reqNS;
      inReqEW = tbl[i].reqEW;
      blinkStep();
      check($sformatf("vec%0d", i), obs(),
            pack(tbl[i].st, tbl[i].ns, tbl[i].ew, tbl[i].walk, tbl[i].latch));
    end

    // no demand: green holds, then exits on the first demanded blink
    doReset();
    blinkStep();
    check("holdEntry", obs(), pack(3'd1, 2'd1, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < 50; i++) begin
      blinkStep();
      check($sformatf("hold%0d", i), obs(), pack(3'd1, 2'd1, 2'd0, 1'b0, 1'b0));
    end
    inReqEW = 1'b1;
    blinkStep();
    check("holdExit", obs(), pack(3'd2, 2'd2, 2'd0, 1'b0, 1'b0));

    // pedestrian press during NS_GREEN leads to a WALK phase, then EW_GREEN
    pedToClear();
    blinkStep();
    check("walkEntry", obs(), pack(3'd5, 2'd0, 2'd0, 1'b1, 1'b0));
    blinkStep();
    blinkStep();
    check("walkHold", obs(), pack(3'd5, 2'd0, 2'd0, 1'b1, 1'b0));
    blinkStep();
    check("walkClear", obs(), pack(3'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    blinkStep();
    check("walkToEw", obs(), pack(3'd3, 2'd0, 2'd1, 1'b0, 1'b0));

    // press coinciding with WALK entry, and a press during WALK, are dropped
    pedToClear();
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    inPedestrian = 1'b1;
    cyc(1'b1);
    check("coincideClear", obs(), pack(3'd5, 2'd0, 2'd0, 1'b1, 1'b0));
    inPedestrian = 1'b0;
    cyc(1'b0);
    inPedestrian = 1'b1;
    cyc(1'b0);
    check("pressInWalk", {8'd0, outPedLatch}, 9'd0);
    inPedestrian = 1'b0;
    cyc(1'b0); cyc(1'b1);
    check("walkMid", obs(), pack(3'd5, 2'd0, 2'd0, 1'b1, 1'b0));
    blinkStep();
    blinkStep();
    blinkStep();
    check("afterWalkEw", obs(), pack(3'd3, 2'd0, 2'd1, 1'b0, 1'b0));

`ifdef SCHED_FLASH_EN
    // flash request runs the yellow/clear sequence, then alternates 2/0
    doReset();
    blinkStep();
    repeat (3) blinkStep();
    inReqEW = 1'b1;
    blinkStep();
    blinkStep();
    blinkStep();
    blinkStep();
    check("flashPreEw", obs(), pack(3'd3, 2'd0, 2'd1, 1'b0, 1'b0));
    inReqEW = 1'b0;
    inFlash = 1'b1;
    repeat (3) blinkStep();
    check("flashEwHold", obs(), pack(3'd3, 2'd0, 2'd1, 1'b0, 1'b0));
    blinkStep();
    check("flashEwYellow", obs(), pack(3'd4, 2'd0, 2'd2, 1'b0, 1'b0));
    blinkStep();
    blinkStep();
    check("flashClear", obs(), pack(3'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    blinkStep();
    check("flashEntry", obs(), pack(3'd6, 2'd0, 2'd0, 1'b0, 1'b0));
    blinkStep();
    check("flashOn", obs(), pack(3'd6, 2'd2, 2'd2, 1'b0, 1'b0));
    blinkStep();
    check("flashOff", obs(), pack(3'd6, 2'd0, 2'd0, 1'b0, 1'b0));
    blinkStep();
    check("flashOn2", obs(), pack(3'd6, 2'd2, 2'd2, 1'b0, 1'b0));
    inFlash = 1'b0;
    blinkStep();
    check("flashExit", obs(), pack(3'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    blinkStep();
    check("flashToNs", obs(), pack(3'd1, 2'd1, 2'd0, 1'b0, 1'b0));
`endif

    // asynchronous reset in the middle of WALK
    pedToClear();
    blinkStep();
    blinkStep();
    check("preAsyncWalk", obs(), pack(3'd5, 2'd0, 2'd0, 1'b1, 1'b0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("asyncReset", obs(), 9'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("afterReset", obs(), 9'd0);
    blinkStep();
    check("restartNs", obs(), pack(3'd1, 2'd1, 2'd0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
